alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational 16-bit ALU. It adds registered outputs, valid/ready flow control on both sides, a WIDTH generic and an iterative signed multiply. It sits between the operand-fetch stage and register writeback. It accepts one operation at a time and holds its result until the consumer takes it.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 68 ++++++
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit positions and FSM states for alu_seq
package alu_pkg;

    localparam logic [7:0] OP_ADD       = 8'h01;
    localparam logic [7:0] OP_SUB       = 8'h02;
    localparam logic [7:0] OP_AND       = 8'h03;
    localparam logic [7:0] OP_OR        = 8'h04;
    localparam logic [7:0] OP_XOR       = 8'h05;
    localparam logic [7:0] OP_NOT_A     = 8'h06;
    localparam logic [7:0] OP_SHL_A     = 8'h07;
    localparam logic [7:0] OP_SHR_A     = 8'h08;
    localparam logic [7:0] OP_NOT_B     = 8'h09;
    localparam logic [7:0] OP_SHL_B     = 8'h0A;
    localparam logic [7:0] OP_SHR_B     = 8'h0B;
    localparam logic [7:0] OP_ASL_A     = 8'h0C;
    localparam logic [7:0] OP_ASR_A     = 8'h0D;
    localparam logic [7:0] OP_ASL_B     = 8'h0E;
    localparam logic [7:0] OP_ASR_B     = 8'h0F;
    localparam logic [7:0] OP_ONE       = 8'h10;
    localparam logic [7:0] OP_MINUS_ONE = 8'h11;
    localparam logic [7:0] OP_MUL       = 8'h12;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - WIDTH-step signed shift-add multiplier (sign-magnitude)
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Operand magnitudes; the most negative value maps onto its unsigned magnitude.
    always_comb begin
        mag_a = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
        mag_b = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;
    end

    // One partial-product step; the final step is exposed directly so the
    // caller can register the product on the same edge the step completes.
    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        done_o    = busy_q && (cnt_q == LAST_STEP);
        product_o = neg_q ? (~acc_d + (2*WIDTH)'(1)) : acc_d;
    end

    // Load operands on start, then shift-add once per cycle until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            acc_q    <= '0;
            mplier_q <= mag_b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked registered ALU; ALU_SEQ_MUL_EN adds iterative MUL
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] op_res;
    logic             op_carry;
    logic             op_ovf;
    logic [3:0]       op_flags;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [3:0]       mul_flags;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_ovf;

    assign is_mul = (opcode == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && is_mul),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Product fits in WIDTH signed bits only if its top WIDTH+1 bits agree.
    always_comb begin
        mul_res   = mul_prod[WIDTH-1:0];
        mul_ovf   = !((&mul_prod[2*WIDTH-1:WIDTH-1]) || (~|mul_prod[2*WIDTH-1:WIDTH-1]));
        mul_flags = '0;
        mul_flags[FLAG_OVF]  = mul_ovf;
        mul_flags[FLAG_ZERO] = (mul_res == '0);
        mul_flags[FLAG_NEG]  = mul_res[WIDTH-1];
    end
`else
    assign is_mul    = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
    assign mul_flags = '0;
`endif

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

    // Single-cycle operation decode with carry/overflow for ADD and SUB.
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        add_full = {1'b0, a} + {1'b0, b};
        sub_res  = a - b;
        case (opcode)
            OP_ADD: begin
                op_res   = add_full[WIDTH-1:0];
                op_carry = add_full[WIDTH];
                op_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res   = sub_res;
                op_carry = (a < b);
                op_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:             op_res = a & b;
            OP_OR:              op_res = a | b;
            OP_XOR:             op_res = a ^ b;
            OP_NOT_A:           op_res = ~a;
            OP_SHL_A, OP_ASL_A: op_res = {a[WIDTH-2:0], 1'b0};
            OP_SHR_A:           op_res = {1'b0, a[WIDTH-1:1]};
            OP_ASR_A:           op_res = {a[WIDTH-1], a[WIDTH-1:1]};
            OP_NOT_B:           op_res = ~b;
            OP_SHL_B, OP_ASL_B: op_res = {b[WIDTH-2:0], 1'b0};
            OP_SHR_B:           op_res = {1'b0, b[WIDTH-1:1]};
            OP_ASR_B:           op_res = {b[WIDTH-1], b[WIDTH-1:1]};
            OP_ONE:             op_res = WIDTH'(1);
            OP_MINUS_ONE:       op_res = '1;
            default:            op_res = '0;
        endcase
        op_flags = '0;
        op_flags[FLAG_CARRY] = op_carry;
        op_flags[FLAG_NEG]   = op_res[WIDTH-1];
        op_flags[FLAG_ZERO]  = (op_res == '0);
        op_flags[FLAG_OVF]   = op_ovf;
    end

    // Next state and output-register load: capture on accept or MUL completion.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = op_res;
                        flags_d  = op_flags;
                    end
                end
            end
            ST_EXEC: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_res;
                    flags_d  = mul_flags;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and held result/flags registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a reference model
module tb_alu_seq;

    localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   opcode = 8'h00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    task automatic model(input logic [7:0] op, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         output logic [W-1:0] r, output logic [3:0] f, output int lat);
        int     ua, ub, sa, sb, full;
        longint p;
        logic   c, v;
        ua = int'(ai);
        ub = int'(bi);
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        c = 1'b0;
        v = 1'b0;
        lat = 1;
        case (op)
            8'h01: begin
                full = ua + ub; r = full[W-1:0]; c = (full > 65535);
                v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            8'h02: begin
                full = ua - ub; r = full[W-1:0]; c = (ua < ub);
                v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            8'h03: r = ai & bi;
            8'h04: r = ai | bi;
            8'h05: r = ai ^ bi;
            8'h06: r = 16'(65535 - ua);
            8'h07, 8'h0C: r = 16'(ua * 2);
            8'h08: r = 16'(ua / 2);
            8'h0D: r = 16'(sa >>> 1);
            8'h09: r = 16'(65535 - ub);
            8'h0A, 8'h0E: r = 16'(ub * 2);
            8'h0B: r = 16'(ub / 2);
            8'h0F: r = 16'(sb >>> 1);
            8'h10: r = 16'd1;
            8'h11: r = 16'hFFFF;
            8'h12: begin
                if (MUL_EN) begin
                    p = longint'(sa) * longint'(sb);
                    r = p[W-1:0];
                    v = (p > 32767) || (p < -32768);
                    lat = W + 1;
                end else begin
                    r = '0;
                end
            end
            default: r = '0;
        endcase
        f = {v, (r == 16'd0), r[W-1], c};
    endtask

    // One full transaction: accept, latency count, optional backpressure, output handshake.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [W-1:0] ai,
                          input logic [W-1:0] bi, input logic [W-1:0] exp_r, input logic [3:0] exp_f,
                          input int exp_lat, input int hold, input bit early_ready);
        int lat;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        opcode = op;
        a = ai;
        b = bi;
        out_ready = early_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 8'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
        end while (!out_valid && lat < 40);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(result), 32'(exp_r));
        check({tag, "_flags"}, 32'(flags), 32'(exp_f));
        if (!early_ready) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_res"}, 32'(result), 32'(exp_r));
                check({tag, "_hold_flags"}, 32'(flags), 32'(exp_f));
                check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_model(input string tag, input logic [7:0] op, input logic [W-1:0] ai,
                             input logic [W-1:0] bi, input int hold, input bit early_ready);
        logic [W-1:0] r;
        logic [3:0]   f;
        int           lat;
        model(op, ai, bi, r, f, lat);
        run_op(tag, op, ai, bi, r, f, lat, hold, early_ready);
    endtask

    initial begin
        logic [7:0] op;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        run_op("add_ovf", 8'h01, 16'h7FFF, 16'h0001, 16'h8000, 4'hA, 1, 0, 1'b0);
        run_op("sub_borrow", 8'h02, 16'h0003, 16'h0005, 16'hFFFE, 4'h3, 1, 0, 1'b0);
        run_op("unknown_op", 8'hFF, 16'h1234, 16'h5678, 16'h0000, 4'h4, 1, 0, 1'b0);
        run_op("add_carry", 8'h01, 16'hFFFF, 16'h0001, 16'h0000, 4'h5, 1, 0, 1'b0);
        run_op("asr_a", 8'h0D, 16'h8002, 16'h0000, 16'hC001, 4'h2, 1, 0, 1'b0);
        run_op("minus_one", 8'h11, 16'h0000, 16'h0000, 16'hFFFF, 4'h2, 1, 0, 1'b0);
        if (MUL_EN) begin
            run_op("mul_neg", 8'h12, 16'hFFFD, 16'h0007, 16'hFFEB, 4'h2, 17, 0, 1'b0);
            run_op("mul_ovf", 8'h12, 16'h0100, 16'h0100, 16'h0000, 4'hC, 17, 0, 1'b0);
        end else begin
            run_op("mul_off", 8'h12, 16'h0002, 16'h0003, 16'h0000, 4'h4, 1, 0, 1'b0);
        end
        run_op("backpressure", 8'h01, 16'h0001, 16'h0001, 16'h0002, 4'h0, 1, 5, 1'b0);

        // Reset in the middle of an operation (mid-MUL when available, else while holding).
        @(negedge clk);
        in_valid = 1'b1;
        opcode = MUL_EN ? 8'h12 : 8'h01;
        a = 16'hFFFD;
        b = 16'h0007;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) check("midrst_stale_valid", 32'(out_valid), 32'd0);
        end
        run_op("post_rst_add", 8'h01, 16'h0002, 16'h0003, 16'h0005, 4'h0, 1, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0:       op = 8'h12;
                1:       op = 8'($urandom);
                default: op = 8'($urandom_range(0, 20));
            endcase
            case ($urandom_range(0, 3))
                0:       a = 16'h8000;
                1:       a = 16'h7FFF;
                default: a = W'($urandom);
            endcase
            b = ($urandom_range(0, 5) == 0) ? 16'hFFFF : W'($urandom);
            run_model("rand", op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
